// File: rtl/timer_ctrl.sv
// Timer sequencer: prescaled down-counter with one-shot/periodic modes,
// pause/resume, abort and rejected-start reporting.
module timer_ctrl #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             running,
  output logic             expire,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e           st_q;
  logic [WIDTH-1:0] reload_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_lat_q;
  logic             mode_q;

  assign state   = st_q;
  assign running = (st_q == RUN);

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      st_q      <= IDLE;
      count     <= '0;
      reload_q  <= '0;
      pre_cnt_q <= '0;
      pre_lat_q <= '0;
      mode_q    <= 1'b0;
      expire    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      expire  <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        st_q      <= IDLE;
        count     <= '0;
        pre_cnt_q <= '0;
      end else if (start && (load_val != '0)) begin
        reload_q  <= load_val;
        mode_q    <= mode;
        pre_lat_q <= prescale;
        count     <= load_val;
        pre_cnt_q <= prescale;
        st_q      <= RUN;
      end else if (start) begin
        cfg_err <= 1'b1;
      end else if ((st_q == RUN) || (st_q == HOLD)) begin
        if (pause) begin
          st_q <= HOLD;
        end else begin
          // Resume edge counts as an active cycle so only paused cycles are lost
          st_q <= RUN;
          if (pre_cnt_q == '0) begin
            pre_cnt_q <= pre_lat_q;
            if (count == WIDTH'(1)) begin
              expire <= 1'b1;
              if (mode_q) begin
                count <= reload_q;
              end else begin
                count <= '0;
                st_q  <= DONE;
              end
            end else begin
              count <= count - WIDTH'(1);
            end
          end else begin
            pre_cnt_q <= pre_cnt_q - PRE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

  localparam int WIDTH = 16;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             clr_b;
  logic             start;
  logic             abort;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             running;
  logic             expire;
  logic             cfg_err;

  int total = 0;
  int fails = 0;

  timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .clr_b    (clr_b),
    .start    (start),
    .abort    (abort),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .prescale (prescale),
    .count    (count),
    .state    (state),
    .running  (running),
    .expire   (expire),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr_b    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    pause    = 1'b0;
    mode     = 1'b0;
    load_val = '0;
    prescale = '0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_expire", 32'(expire), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    #9 clr_b = 1'b1;
    cyc();

    // one-shot, load 3, prescale 0
    mode = 1'b0; load_val = 16'd3; prescale = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("os_e0_count", 32'(count), 32'd3);
    chk("os_e0_running", 32'(running), 32'd1);
    cyc();
    chk("os_e1_count", 32'(count), 32'd2);
    cyc();
    chk("os_e2_count", 32'(count), 32'd1);
    chk("os_e2_expire", 32'(expire), 32'd0);
    cyc();
    chk("os_e3_count", 32'(count), 32'd0);
    chk("os_e3_expire", 32'(expire), 32'd1);
    chk("os_e3_state", 32'(state), 32'd3);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("os_done_count", 32'(count), 32'd0);
      chk("os_done_expire", 32'(expire), 32'd0);
      chk("os_done_state", 32'(state), 32'd3);
    end

    // periodic, load 2, prescale 3: period 8
    mode = 1'b1; load_val = 16'd2; prescale = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("per_e0_count", 32'(count), 32'd2);
    for (int i = 1; i <= 24; i++) begin
      cyc();
      chk("per_expire", 32'(expire), 32'((i % 8) == 0));
      chk("per_count", 32'(count), ((i % 8) >= 4) ? 32'd1 : 32'd2);
      chk("per_running", 32'(running), 32'd1);
    end

    // abort wins over start
    abort = 1'b1; start = 1'b1; load_val = 16'd4;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_expire", 32'(expire), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("abort_quiet", 32'(expire), 32'd0);
    end

    // pause: one-shot, load 5, prescale 1, paused 7 cycles after cycle 4
    mode = 1'b0; load_val = 16'd5; prescale = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) cyc();
    chk("pz_e4_count", 32'(count), 32'd3);
    pause = 1'b1;
    for (int i = 5; i <= 11; i++) begin
      cyc();
      chk("pz_hold_count", 32'(count), 32'd3);
      chk("pz_hold_state", 32'(state), 32'd2);
      chk("pz_hold_running", 32'(running), 32'd0);
    end
    pause = 1'b0;
    for (int i = 12; i <= 17; i++) begin
      cyc();
      chk("pz_expire", 32'(expire), 32'(i == 17));
    end
    chk("pz_end_state", 32'(state), 32'd3);
    chk("pz_end_count", 32'(count), 32'd0);

    // restart mid-run with load 9 restarts the prescaler
    mode = 1'b0; load_val = 16'd5; prescale = 8'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    load_val = 16'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rs_count0", 32'(count), 32'd9);
    cyc();
    cyc();
    chk("rs_count2", 32'(count), 32'd9);
    cyc();
    chk("rs_count3", 32'(count), 32'd8);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // zero load from IDLE
    load_val = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("z_idle_err", 32'(cfg_err), 32'd1);
    chk("z_idle_state", 32'(state), 32'd0);
    cyc();
    chk("z_idle_err_off", 32'(cfg_err), 32'd0);

    // zero load from DONE
    mode = 1'b0; load_val = 16'd1; prescale = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("z_pre_done", 32'(state), 32'd3);
    load_val = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("z_done_err", 32'(cfg_err), 32'd1);
    chk("z_done_state", 32'(state), 32'd3);
    chk("z_done_count", 32'(count), 32'd0);
    cyc();
    chk("z_done_err_off", 32'(cfg_err), 32'd0);

    // async reset mid-run at count 7
    mode = 1'b0; load_val = 16'd9; prescale = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("ar_count7", 32'(count), 32'd7);
    #3 clr_b = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_running", 32'(running), 32'd0);
    #2 clr_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("ar_no_expire", 32'(expire), 32'd0);
      chk("ar_idle", 32'(state), 32'd0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Controller that sequences the timer's down-counter datapath.
- Loads a programmed count and drives a prescaler that generates count ticks.
- Decrements the count on each tick and flags expiry.
- Supports one-shot and periodic modes, plus pause/resume and abort.
- Sits between the host/config logic and the flop-based counter chain; its outputs are the timer's status and interrupt source.

Parameters:
WIDTH, 16, bit width of load value and count
PRE_W, 8, bit width of prescaler value

Ports:
clk  input  1  system clock, rising-edge
clr_b  input  1  asynchronous active-low reset/clear
start  input  1  pulse: load count and begin running
abort  input  1  pulse: stop immediately and return to IDLE
pause  input  1  level: freeze counting while high
mode  input  1  0 = one-shot, 1 = periodic; sampled at start
load_val  input  WIDTH  initial/reload count; sampled at start
prescale  input  PRE_W  tick divisor minus 1; sampled at start
count  output  WIDTH  current count value
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11
running  output  1  high in RUN only
expire  output  1  one-cycle pulse on count reaching 0
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock, clk. Reset clr_b is asynchronous, active-low.
- Reset (clr_b=0, asynchronous): state=IDLE, count=0, expire=0, cfg_err=0, running=0. Internal registers are cleared: reload, prescaler counter, latched prescale, latched mode. Everything else is synchronous to the rising edge of clk.
- All outputs are registered. running is decoded from the state register.
- Priority per cycle: abort > start > pause > tick.
- abort, any state: next state=IDLE, count=0, no expire, prescaler cleared.
- start, any state when abort=0, with load_val != 0:
  - Latch load_val into reload, mode, and prescale.
  - count<=load_val, prescaler counter<=prescale, state<=RUN.
  - A start during RUN or HOLD restarts the timer.
- start with load_val==0: ignored. State and count are unchanged, and cfg_err pulses for 1 cycle.
- Prescaler (RUN only):
  - Each cycle: if prescaler counter==0, a tick occurs and the counter reloads the latched prescale; otherwise it decrements.
  - The first tick comes prescale+1 cycles after the start edge. prescale=0 gives a tick every cycle.
- Tick in RUN with count>1: count<=count-1.
- Tick in RUN with count==1:
  - expire<=1 for exactly one cycle.
  - One-shot: count<=0, state<=DONE.
  - Periodic: count<=reload, state stays RUN.
- Timing:
  - Expiry comes load_val*(prescale+1) cycles after the start edge.
  - In periodic mode the period is load_val*(prescale+1) cycles.
- Pause:
  - RUN with pause=1 goes to HOLD. Count and prescaler counter are frozen; no ticks occur.
  - HOLD with pause=0 returns to RUN and resumes from the frozen values. No cycles are lost apart from the paused ones.
  - pause in IDLE/DONE has no effect.
  - A start with pause=1 goes to RUN, then to HOLD next cycle if pause is still high.
- DONE: count holds 0 until start or abort. DONE accepts start like IDLE.
- Reset mid-operation: immediate return to reset values. No expire is emitted.
- Count arithmetic is unsigned WIDTH-bit. The count never wraps below 0; count==0 is only reachable in IDLE/DONE.
- Inputs are synchronous to clk. No internal synchronisers.

Test Plan:
- Reset then one-shot: mode=0, load_val=3, prescale=0, start at E0.
  - Required: count 3,2,1,0 after E0..E3.
  - Required: expire high only after E3; state=DONE; count holds 0 for 10 cycles.
- Prescaled periodic: mode=1, load_val=2, prescale=3.
  - Required: expire pulses every 8 cycles, first at cycle 8 after start.
  - Required: count reloads to 2; running stays 1.
- Pause: one-shot, load_val=5, prescale=1; pause=1 for 7 cycles after cycle 4.
  - Required: count frozen during the pause; state=HOLD.
  - Required: expire at cycle 10+7=17.
- Abort and priority: abort and start in the same cycle during RUN.
  - Required: state=IDLE, count=0, no expire.
  - Separately, start mid-RUN with load_val=9: count=9, prescaler restarted.
- Zero load: start with load_val=0 from IDLE.
  - Required: cfg_err one-cycle pulse; state stays IDLE.
  - Same stimulus from DONE: state stays DONE.
- Asynchronous reset: drop clr_b mid-cycle during RUN with count=7.
  - Required: outputs go to 0/IDLE before the next clk edge.
  - Required: after release, no expire until a new start.
